// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column output FIFO between the MAC array and the SFU.
// Each column has its own circular buffer, so lanes can be written on a
// skewed diagonal schedule. All lanes pop together once every lane has data.
// The output is first-word fall-through.
// Optional feature: define PSUM_OFIFO_OVF_EN to add the sticky o_ovf flag.
// o_ovf sets on a dropped write or an ignored pop.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr_i,
    input  logic [psum_bw*col-1:0] in,
    input  logic                   rd_i,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready
`ifdef PSUM_OFIFO_OVF_EN
    ,
    output logic                   o_ovf
`endif
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [psum_bw-1:0] mem_q  [col][depth];
    logic [PW-1:0]      wptr_q [col];
    logic [PW-1:0]      wptr_d [col];
    logic [PW-1:0]      rptr_q [col];
    logic [PW-1:0]      rptr_d [col];

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] wr_en;
    logic           pop;

    // Per-lane status from pre-edge pointers; the extra MSB separates full from empty.
    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        wr_en      = '0;
        for (int c = 0; c < col; c++) begin
            lane_empty[c] = (wptr_q[c] == rptr_q[c]);
            lane_full[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                            (wptr_q[c][AW] != rptr_q[c][AW]);
            wr_en[c]      = wr_i[c] & ~lane_full[c];
        end
    end

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd_i & o_valid;

    // Next pointers: writes advance per lane, a pop advances every lane at once.
    always_comb begin
        for (int c = 0; c < col; c++) begin
            wptr_d[c] = wr_en[c] ? (wptr_q[c] + PW'(1)) : wptr_q[c];
            rptr_d[c] = pop      ? (rptr_q[c] + PW'(1)) : rptr_q[c];
        end
    end

    // Fall-through head: each lane's slot at its read pointer drives its column of out.
    always_comb begin
        out = '0;
        for (int c = 0; c < col; c++) begin
            out[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c][AW-1:0]];
        end
    end

    // Pointer and storage update.
    // Reset also clears storage, so out reads zero while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                for (int d = 0; d < depth; d++) begin
                    mem_q[c][d] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                if (wr_en[c]) begin
                    mem_q[c][wptr_q[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
                end
            end
        end
    end

`ifdef PSUM_OFIFO_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = ovf_q | (|(wr_i & lane_full)) | (rd_i & ~o_valid);
    assign o_ovf = ovf_q;

    // Sticky overflow/underflow flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Testbench for psum_ofifo. It uses the default parameters.
// A reference model built from per-lane queues gives the expected outputs.
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 8;
    localparam int DW    = COL * BW;

    logic          clk;
    logic          reset;
    logic [COL-1:0] wr_i;
    logic [DW-1:0]  in;
    logic           rd_i;
    logic [DW-1:0]  out;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
`ifdef PSUM_OFIFO_OVF_EN
    logic           o_ovf;
`endif

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_i    (wr_i),
        .in      (in),
        .rd_i    (rd_i),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready)
`ifdef PSUM_OFIFO_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [BW-1:0] mq [COL][$];
    logic          m_ovf;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. Inputs are applied first.
    // Outputs are checked against the model at the falling edge.
    // The model then advances at the next rising edge.
    task automatic step(input logic [COL-1:0] wr, input logic [DW-1:0] data, input logic rd);
        logic           e_valid;
        logic           e_full;
        logic [COL-1:0] full_v;
        logic [DW-1:0]  e_out;
        wr_i = wr;
        in   = data;
        rd_i = rd;
        @(negedge clk);
        e_valid = 1'b1;
        e_full  = 1'b0;
        full_v  = '0;
        e_out   = '0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0) e_valid = 1'b0;
            if (mq[c].size() == DEPTH) begin
                e_full    = 1'b1;
                full_v[c] = 1'b1;
            end
        end
        chk("o_valid", DW'(o_valid), DW'(e_valid));
        chk("o_full",  DW'(o_full),  DW'(e_full));
        chk("o_ready", DW'(o_ready), DW'(!e_full));
        if (e_valid) begin
            for (int c = 0; c < COL; c++) e_out[c*BW +: BW] = mq[c][0];
            chk("out", out, e_out);
        end
`ifdef PSUM_OFIFO_OVF_EN
        chk("o_ovf", DW'(o_ovf), DW'(m_ovf));
`endif
        @(posedge clk);
        if (rd) begin
            if (e_valid) begin
                for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
            end else begin
                m_ovf = 1'b1;
            end
        end
        for (int c = 0; c < COL; c++) begin
            if (wr[c]) begin
                if (full_v[c]) m_ovf = 1'b1;
                else mq[c].push_back(data[c*BW +: BW]);
            end
        end
        #1;
    endtask

    // Reset is asserted between clock edges.
    // The outputs must clear before any edge arrives.
    // Traffic presented while reset is held must be ignored.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", DW'(o_valid), DW'(1'b0));
        chk("rst_out",   out,          '0);
        chk("rst_full",  DW'(o_full),  DW'(1'b0));
        chk("rst_ready", DW'(o_ready), DW'(1'b1));
        for (int c = 0; c < COL; c++) mq[c].delete();
        m_ovf = 1'b0;
        wr_i  = '1;
        in    = {DW{1'b1}};
        rd_i  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_valid", DW'(o_valid), DW'(1'b0));
        chk("rst_hold_out",   out,          '0);
        @(negedge clk);
        reset = 1'b0;
        wr_i  = '0;
        rd_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] row_of(input int base, input int step_c);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + step_c * c);
        return r;
    endfunction

    initial begin
        logic [DW-1:0]  d;
        logic [COL-1:0] w;
        reset = 1'b1;
        wr_i  = '0;
        in    = '0;
        rd_i  = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        async_reset();

        // All lanes are written in one cycle, then popped once.
        step('1, row_of(16'h0100, 1), 1'b0);
        chk("all_lanes_row", out, row_of(16'h0100, 1));
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Skewed diagonal fill: lane c is written on cycles c..c+2 with values 1,2,3.
        async_reset();
        for (int t = 0; t < COL + 2; t++) begin
            w = '0;
            d = '0;
            for (int c = 0; c < COL; c++) begin
                if (t >= c && t <= c + 2) begin
                    w[c]          = 1'b1;
                    d[c*BW +: BW] = BW'(t - c + 1);
                end
            end
            step(w, d, 1'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            chk("skew_row", out, row_of(k, 0));
            step('0, '0, 1'b1);
        end
        step('0, '0, 1'b0);

        // Lane 0 is filled alone. A ninth write is dropped, and a pop with no valid row is ignored.
        async_reset();
        for (int k = 0; k < DEPTH + 1; k++) step(8'h01, DW'(k + 16'h50), 1'b0);
        step(8'h00, '0, 1'b1);
        // A pop and a write hit the full lane in the same cycle: the pop happens and the write is dropped.
        step(8'hFE, row_of(16'h0A00, 1), 1'b0);
        step(8'h01, DW'(16'hDEAD), 1'b1);
        step(8'h00, '0, 1'b0);
        for (int k = 0; k < DEPTH; k++) step(8'hFE, row_of(16'h0B00 + k, 0), 1'b0);

        // Wrap-around: occupancy stays at one entry for 20 write+pop pairs.
        async_reset();
        step('1, row_of(0, 0), 1'b0);
        for (int k = 1; k <= 20; k++) step('1, row_of(k, 0), 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);

        // Reset arrives mid-stream with 5 rows queued. After release, a fresh row is read first.
        for (int k = 0; k < 5; k++) step('1, row_of(16'h0300 + k, 1), 1'b0);
        async_reset();
        step('1, row_of(16'h0777, 0), 1'b0);
        chk("post_rst_first", out, row_of(16'h0777, 0));
        step('0, '0, 1'b1);

        // Random traffic across several write-density and pop-rate phases.
        async_reset();
        for (int k = 0; k < 400; k++) begin
            case ((k / 50) % 4)
                0: w = COL'($urandom);
                1: w = COL'($urandom | $urandom);
                2: w = COL'($urandom & $urandom);
                default: w = '1;
            endcase
            for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'($urandom);
            step(w, d, ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 50 : 25)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
